// File: rtl/alu_ctrl_pkg.sv
// Shared ALU opcode and flag codes plus the arbiter FSM state encoding.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    localparam logic [1:0] FLAG_POS  = 2'b00;
    localparam logic [1:0] FLAG_NEG  = 2'b01;
    localparam logic [1:0] FLAG_ZERO = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant_o = 2'b00;
        unique case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two valid/ready requesters; operands
// and results are registered, one transaction in flight at a time.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int OPW   = 3,
    parameter int FLAGW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [DW-1:0]    req_a0,
    input  logic [DW-1:0]    req_b0,
    input  logic [OPW-1:0]   req_op0,
    input  logic [DW-1:0]    req_a1,
    input  logic [DW-1:0]    req_b1,
    input  logic [OPW-1:0]   req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [DW-1:0]    rsp_data,
    output logic [FLAGW-1:0] rsp_flag,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [DW-1:0]    alu_c,
    input  logic [FLAGW-1:0] alu_flag
);

    state_e            state_q, state_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [OPW-1:0]    op_q, op_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DW-1:0]     data_q, data_d;
    logic [FLAGW-1:0]  flag_q, flag_d;
    logic [1:0]        grant;

    rr_arb2 u_arb (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        flag_d       = flag_q;
        req_ready    = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                // Grant is offered only while out of reset so ready reads 0 during rst.
                req_ready = rst ? 2'b00 : grant;
                if (|(req_valid & grant)) begin
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    a_d          = grant[1] ? req_a1  : req_a0;
                    b_d          = grant[1] ? req_b1  : req_b0;
                    op_d         = grant[1] ? req_op1 : req_op0;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                data_d  = alu_c;
                flag_d  = alu_flag;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            flag_q       <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            flag_q       <= flag_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_q;
    assign rsp_flag  = flag_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;

endmodule
